// File: rtl/geofence_pkg.sv
// Shared constants and phase encoding for the geofence sequencer.
package geofence_pkg;
  localparam int N_FENCE   = 6;
  localparam int IDX_W     = 3;
  localparam int SORT_CMPS = (N_FENCE - 1) * (N_FENCE - 2) / 2;
  localparam int TEST_CMPS = N_FENCE;

  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(N_FENCE);
  localparam logic [IDX_W-1:0] LAST_EDGE = IDX_W'(TEST_CMPS - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_TEST,
    S_DONE
  } state_t;
endpackage

// File: rtl/geofence_seq_sort_sched.sv
// Bubble-sort compare schedule: walks (j, j+1) pairs over slots 2..N_FENCE,
// shrinking each pass by one, and flags the final compare of the last pass.
module sort_sched
  import geofence_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [IDX_W-1:0] op_b,
  output logic [IDX_W-1:0] op_c,
  output logic             last_cmp
);

  logic [1:0]       pass;
  logic [IDX_W-1:0] j_off;   // j - 2, so both counters reset to zero
  logic [IDX_W-1:0] pass_end;
  logic             end_of_pass;

  assign pass_end    = IDX_W'(N_FENCE - 3) - IDX_W'(pass);
  assign end_of_pass = (j_off == pass_end);
  assign last_cmp    = end_of_pass && (pass == 2'(N_FENCE - 3));
  assign op_b        = j_off + IDX_W'(2);
  assign op_c        = j_off + IDX_W'(3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass  <= '0;
      j_off <= '0;
    end else if (en) begin
      if (end_of_pass) begin
        j_off <= '0;
        pass  <= last_cmp ? 2'd0 : pass + 2'd1;
      end else begin
        j_off <= j_off + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/geofence_seq.sv
// Per-frame sequencer: load target + fence, angle-sort fence around vertex 1,
// test target against every edge, then strobe the inside/outside verdict.
module geofence_seq
  import geofence_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic             load,
  output logic [IDX_W-1:0] ld_idx,
  output logic [IDX_W-1:0] op_a,
  output logic [IDX_W-1:0] op_b,
  output logic [IDX_W-1:0] op_c,
  input  logic             cp_neg,
  output logic             swap,
  output logic             valid,
  output logic             is_inside
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] slot_cnt, slot_nxt;
  logic             out_flag, flag_nxt;
  logic             sort_en;
  logic             last_cmp;
  logic [IDX_W-1:0] sort_b, sort_c;

  sort_sched u_sort_sched (
    .clk      (clk),
    .reset    (reset),
    .en       (sort_en),
    .op_b     (sort_b),
    .op_c     (sort_c),
    .last_cmp (last_cmp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_LOAD;
      slot_cnt <= '0;
      out_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      slot_cnt <= slot_nxt;
      out_flag <= flag_nxt;
    end
  end

  // slot_cnt is shared: load slot in S_LOAD, edge index k-1 in S_TEST.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_cnt;
    flag_nxt  = out_flag;
    sort_en   = 1'b0;
    load      = 1'b0;
    ld_idx    = '0;
    op_a      = '0;
    op_b      = '0;
    op_c      = '0;
    swap      = 1'b0;
    valid     = 1'b0;
    is_inside = 1'b0;
    case (state)
      S_LOAD: begin
        load   = 1'b1;
        ld_idx = slot_cnt;
        if (slot_cnt == LAST_SLOT) begin
          slot_nxt  = '0;
          state_nxt = S_SORT;
        end else begin
          slot_nxt = slot_cnt + IDX_W'(1);
        end
      end
      S_SORT: begin
        op_a    = IDX_W'(1);
        op_b    = sort_b;
        op_c    = sort_c;
        swap    = cp_neg;
        sort_en = 1'b1;
        if (last_cmp) state_nxt = S_TEST;
      end
      S_TEST: begin
        // Edge k -> k+1 with wrap back to vertex 1; a zero cross product stays inside.
        op_a     = slot_cnt + IDX_W'(1);
        op_b     = (slot_cnt == LAST_EDGE) ? IDX_W'(1) : slot_cnt + IDX_W'(2);
        op_c     = '0;
        flag_nxt = out_flag | cp_neg;
        if (slot_cnt == LAST_EDGE) begin
          slot_nxt  = '0;
          state_nxt = S_DONE;
        end else begin
          slot_nxt = slot_cnt + IDX_W'(1);
        end
      end
      S_DONE: begin
        valid     = 1'b1;
        is_inside = ~out_flag;
        flag_nxt  = 1'b0;
        state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

endmodule

// File: tb/tb_geofence_seq.sv
// Randomized + directed bench; expected outputs come from a cycle-in-frame model.
module tb_geofence_seq;
  localparam int NF     = 6;
  localparam int FRAME  = 24;
  localparam int NSORT  = (NF - 1) * (NF - 2) / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cp_neg = 1'b0;
  logic       load, swap, valid, is_inside;
  logic [2:0] ld_idx, op_a, op_b, op_c;

  int errors = 0;
  int checks = 0;
  int t = 0;        // cycle within frame
  bit oflag = 0;    // any negative edge test seen this frame
  int sort_b[NSORT];

  geofence_seq dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .ld_idx    (ld_idx),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_c      (op_c),
    .cp_neg    (cp_neg),
    .swap      (swap),
    .valid     (valid),
    .is_inside (is_inside)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input bit cn);
    int e_load, e_ld, e_a, e_b, e_c, e_swap, e_valid, e_in, k;
    e_load = (t < 7); e_ld = (t < 7) ? t : 0;
    e_a = 0; e_b = 0; e_c = 0; e_swap = 0;
    e_valid = (t == 23);
    e_in = e_valid && !oflag;
    if (t >= 7 && t < 7 + NSORT) begin
      e_a = 1; e_b = sort_b[t-7]; e_c = e_b + 1; e_swap = cn;
    end
    if (t >= 17 && t <= 22) begin
      k = t - 16;
      e_a = k; e_b = (k % NF) + 1; e_c = 0;
    end
    chk($sformatf("t%0d load", t), 32'(load), 32'(e_load));
    chk($sformatf("t%0d ld_idx", t), 32'(ld_idx), 32'(e_ld));
    chk($sformatf("t%0d op_a", t), 32'(op_a), 32'(e_a));
    chk($sformatf("t%0d op_b", t), 32'(op_b), 32'(e_b));
    chk($sformatf("t%0d op_c", t), 32'(op_c), 32'(e_c));
    chk($sformatf("t%0d swap", t), 32'(swap), 32'(e_swap));
    chk($sformatf("t%0d valid", t), 32'(valid), 32'(e_valid));
    chk($sformatf("t%0d is_inside", t), 32'(is_inside), 32'(e_in));
  endtask

  // Entered at posedge+1; leaves at the next posedge+1.
  task automatic do_cycle(input int mode);
    bit cn;
    case (mode)
      0: cn = 1'b0;
      1: cn = (t == 7 || t == 12);
      2: cn = (t == 20);
      3: cn = 1'b1;
      default: cn = 1'($urandom_range(0, 1));
    endcase
    #1 cp_neg = cn;
    #2 check_outputs(cn);
    if (t >= 17 && t <= 22 && cn) oflag = 1;
    t = (t + 1) % FRAME;
    if (t == 0) oflag = 0;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int mode);
    for (int i = 0; i < FRAME; i++) do_cycle(mode);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " load"}, 32'(load), 32'd1);
    chk({tag, " ld_idx"}, 32'(ld_idx), 32'd0);
    chk({tag, " op_a"}, 32'(op_a), 32'd0);
    chk({tag, " op_b"}, 32'(op_b), 32'd0);
    chk({tag, " op_c"}, 32'(op_c), 32'd0);
    chk({tag, " swap"}, 32'(swap), 32'd0);
    chk({tag, " valid"}, 32'(valid), 32'd0);
    chk({tag, " is_inside"}, 32'(is_inside), 32'd0);
  endtask

  initial begin
    int n = 0;
    for (int p = 0; p <= NF - 3; p++)
      for (int j = 2; j <= NF - 1 - p; j++) begin
        sort_b[n] = j;
        n++;
      end

    #2 reset = 1'b1;
    #1 check_reset_vals("rst_assert");
    repeat (2) @(posedge clk);
    #1 check_reset_vals("rst_hold");
    reset = 1'b0;
    t = 0; oflag = 0;

    run_frame(0);   // plain inside, no swaps
    run_frame(1);   // swaps on cycles 7 and 12
    run_frame(2);   // negative only at k=4 -> outside
    run_frame(3);   // outside, back-to-back with...
    run_frame(0);   // ...inside: flag must have cleared
    for (int f = 0; f < 6; f++) run_frame(4);

    // Abort mid-sort at cycle 12.
    for (int i = 0; i < 12; i++) do_cycle(4);
    #1 cp_neg = 1'b1;
    #1 reset = 1'b1;
    #1 check_reset_vals("midrst_async");
    @(posedge clk);
    #1 check_reset_vals("midrst_hold");
    reset = 1'b0;
    t = 0; oflag = 0;
    run_frame(0);
    run_frame(4);
    run_frame(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
